// File: rtl/inst_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_pkg
// Shared encodings for the instruction-fetch stage:
//   PC_*        controller next-PC source select (3 bits)
//   if_state_e  IF FSM states IF_IDLE / IF_REQ / IF_HOLD / IF_KILL
//   INST_NOP    instruction presented when the output buffer is empty
// -----------------------------------------------------------------------------
package inst_fetch_stage_pkg;

  localparam logic [2:0] PC_NEXT     = 3'd0;
  localparam logic [2:0] PC_JUMP     = 3'd1;
  localparam logic [2:0] PC_BRANCH   = 3'd2;
  localparam logic [2:0] PC_FWD_DATA = 3'd3;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2,
    IF_KILL = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetch_stage_next_pc.sv
// -----------------------------------------------------------------------------
// if_next_pc
// Combinational redirect-target mux for the fetch stage.
// Ports:
//   pc_src_i       controller PC source select
//   id_pc_plus4_i  PC+4 of the instruction in ID
//   id_imm_ext_i   sign-extended immediate (branch word offset)
//   id_jidx_i      26-bit jump index
//   id_rs_fwd_i    forwarded rs value (register jump target)
//   target_o       redirect target, always word aligned
//   misalign_o     register-jump target had non-zero low bits
// Unknown select codes fall through to id_pc_plus4_i.
// -----------------------------------------------------------------------------
module if_next_pc
  import inst_fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        pc_src_i,
  input  logic [ADDR_W-1:0] id_pc_plus4_i,
  input  logic [31:0]       id_imm_ext_i,
  input  logic [25:0]       id_jidx_i,
  input  logic [31:0]       id_rs_fwd_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              misalign_o
);

  always_comb begin
    target_o   = id_pc_plus4_i;
    misalign_o = 1'b0;
    case (pc_src_i)
      // Offset is in words; the add wraps naturally at 2^ADDR_W.
      PC_BRANCH:   target_o = id_pc_plus4_i + (id_imm_ext_i << 2);
      PC_JUMP:     target_o = {id_pc_plus4_i[ADDR_W-1:ADDR_W-4], id_jidx_i, 2'b00};
      PC_FWD_DATA: begin
        target_o   = {id_rs_fwd_i[ADDR_W-1:2], 2'b00};
        misalign_o = |id_rs_fwd_i[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
// IF stage of the 5-stage MIPS pipeline. Owns the PC, runs a req/ack fetch to
// instruction memory and presents {inst, pc, pc_plus4, if_valid} to IF/ID.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_rst              stage flush, same effect as rst
//   if_en               1: IF/ID consumes the current output this cycle
//   pc_src              next-PC source; anything but PC_NEXT with if_en redirects
//   id_pc_plus4, id_imm_ext, id_jidx, id_rs_fwd   redirect operands from ID
//   imem_req/imem_addr  fetch request, held with a stable address until imem_ack
//   imem_ack/imem_rdata response strobe and instruction word
//   inst, pc, pc_plus4, if_valid   registered output buffer
//   if_misalign         one-cycle pulse: register-jump target not word aligned
//   dbg_if_state        current FSM state (if_state_e encoding)
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt, perf_kill_cnt and
// perf_stall_cnt outputs.
//
// Handshake: a request is raised with imem_addr and both stay unchanged until
// the cycle imem_ack is high; that cycle completes the transfer. The memory
// cannot be back-pressured, so an ack arriving while the output buffer is
// full and not consumed is parked in a one-word pending register and the FSM
// stops requesting (HOLD) until the consumer drains it.
// -----------------------------------------------------------------------------
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_rst,
  input  logic              if_en,
  input  logic [2:0]        pc_src,
  input  logic [ADDR_W-1:0] id_pc_plus4,
  input  logic [31:0]       id_imm_ext,
  input  logic [25:0]       id_jidx,
  input  logic [31:0]       id_rs_fwd,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              if_valid,
  output logic              if_misalign,
  output logic [1:0]        dbg_if_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  if_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nfpc_q, nfpc_d;      // next fetch PC
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic [31:0]       pend_inst_q, pend_inst_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_v_q, pend_v_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              target_mis;
  logic [ADDR_W-1:0] ack_pc4;

  if_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_src_i      (pc_src),
    .id_pc_plus4_i (id_pc_plus4),
    .id_imm_ext_i  (id_imm_ext),
    .id_jidx_i     (id_jidx),
    .id_rs_fwd_i   (id_rs_fwd),
    .target_o      (target),
    .misalign_o    (target_mis)
  );

  assign redirect = if_en && (pc_src != PC_NEXT);
  assign ack_pc4  = addr_q + WORD_STEP;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    nfpc_d      = nfpc_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    mis_d       = 1'b0;
    pend_inst_d = pend_inst_q;
    pend_pc_d   = pend_pc_q;
    pend_v_d    = pend_v_q;

    // IF/ID takes the buffer whenever if_en is high; it empties unless refilled below.
    if (if_en) begin
      valid_d = 1'b0;
      inst_d  = INST_NOP;
    end

    // No delay slot: a redirect drops whatever IF currently holds.
    if (redirect) begin
      nfpc_d   = target;
      mis_d    = target_mis;
      pend_v_d = 1'b0;
    end

    case (state_q)
      IF_IDLE: begin
        state_d = IF_REQ;
        req_d   = 1'b1;
        addr_d  = nfpc_d;
      end

      IF_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            // Response belongs to the wrong path; reissue at the target at once.
            addr_d = target;
          end else begin
            nfpc_d = ack_pc4;
            if (!valid_q || if_en) begin
              valid_d = 1'b1;
              inst_d  = imem_rdata;
              pc_d    = addr_q;
              pc4_d   = ack_pc4;
              if (if_en) begin
                addr_d = ack_pc4;
              end else begin
                state_d = IF_HOLD;
                req_d   = 1'b0;
              end
            end else begin
              pend_v_d    = 1'b1;
              pend_inst_d = imem_rdata;
              pend_pc_d   = addr_q;
              state_d     = IF_HOLD;
              req_d       = 1'b0;
            end
          end
        end else if (redirect) begin
          state_d = IF_KILL;
        end
      end

      IF_HOLD: begin
        if (redirect) begin
          state_d = IF_REQ;
          req_d   = 1'b1;
          addr_d  = target;
        end else if (if_en) begin
          state_d = IF_REQ;
          req_d   = 1'b1;
          addr_d  = nfpc_q;
          if (pend_v_q) begin
            valid_d  = 1'b1;
            inst_d   = pend_inst_q;
            pc_d     = pend_pc_q;
            pc4_d    = pend_pc_q + WORD_STEP;
            pend_v_d = 1'b0;
          end
        end
      end

      IF_KILL: begin
        // Request stays up at its original address until the stale ack shows.
        if (imem_ack) begin
          state_d = IF_REQ;
          addr_d  = nfpc_d;
        end
      end

      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || if_rst) begin
      // An in-flight request keeps its address and is drained through KILL so
      // the memory handshake is never abandoned half way.
      if (req_q && !imem_ack) begin
        state_q <= IF_KILL;
        req_q   <= 1'b1;
      end else begin
        state_q <= IF_IDLE;
        req_q   <= 1'b0;
      end
      nfpc_q   <= RESET_PC;
      inst_q   <= INST_NOP;
      pc_q     <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      pend_v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      nfpc_q      <= nfpc_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      pend_inst_q <= pend_inst_d;
      pend_pc_q   <= pend_pc_d;
      pend_v_q    <= pend_v_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign inst         = inst_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc4_q;
  assign if_valid     = valid_q;
  assign if_misalign  = mis_q;
  assign dbg_if_state = state_q;

`ifdef IF_PERF_CNT_EN
  logic fetch_ev;
  logic kill_ev;
  logic [31:0] fetch_cnt_q, kill_cnt_q, stall_cnt_q;

  assign fetch_ev = (state_q == IF_REQ) && imem_ack && !redirect;
  assign kill_ev  = imem_ack && ((state_q == IF_KILL) || ((state_q == IF_REQ) && redirect));

  always_ff @(posedge clk) begin
    if (rst || if_rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_ev)            fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (kill_ev)             kill_cnt_q  <= kill_cnt_q + 32'd1;
      if (valid_q && !if_en)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_kill_cnt  = kill_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
